// File: rtl/sram_like_arbiter_if.sv
// sram-like bus bundle shared by the CPU masters and the slave port.
// master: drives req/wr/size/wstrb/addr/wdata; slave: drives addr_ok/data_ok/rdata.
interface sram_like_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [3:0]        wstrb;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [ADDR_W-1:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_like_arbiter.sv
// Two-master sram-like arbiter: inst/data share one slave port.
// Address phase is arbitrated and locked until handshake; an in-order
// owner FIFO steers each data_ok/rdata back to the requesting master.
// Ports: clk, resetn (async, active low), inst/data (slave modports,
// CPU side), s (master modport, memory side), outstanding (FIFO
// occupancy), err_orphan (sticky: s.data_ok seen with FIFO empty).
// Option: define ARB_ROUND_ROBIN_EN for round-robin between masters;
// default is fixed priority, data over inst.
module sram_like_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_W          = 32
) (
  input  logic                         clk,
  input  logic                         resetn,
  sram_like_arbiter_if.slave           inst,
  sram_like_arbiter_if.slave           data,
  sram_like_arbiter_if.master          s,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
  output logic                         err_orphan
);

  localparam int PW = (MAX_OUTSTANDING > 1) ?
                      $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  // owner encoding: 0 = inst, 1 = data
  logic                       lock_q, lock_d;
  logic                       lown_q, lown_d;
  logic [MAX_OUTSTANDING-1:0] fifo_q;
  logic [PW-1:0]              wptr_q, rptr_q;
  logic [CW-1:0]              cnt_q;
  logic                       err_q;
`ifdef ARB_ROUND_ROBIN_EN
  logic                       rr_q;
`endif

  logic full, empty;
  logic gnt, greq;
  logic s_req, hs, pop, head;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (cnt_q == CW'(MAX_OUTSTANDING));
  assign empty = (cnt_q == '0);

  always_comb begin
    gnt = 1'b0;
    if (lock_q)
      gnt = lown_q;
`ifdef ARB_ROUND_ROBIN_EN
    else if (data.req && inst.req)
      gnt = rr_q;
`endif
    else if (data.req)
      gnt = 1'b1;
    else
      gnt = 1'b0;
  end

  assign greq  = gnt ? data.req : inst.req;
  // resetn gating keeps every handshake low while reset is held
  assign s_req = resetn & greq & ~full;
  assign hs    = s_req & s.addr_ok;
  assign pop   = resetn & s.data_ok & ~empty;
  assign head  = fifo_q[rptr_q];

  assign s.req   = s_req;
  assign s.wr    = gnt ? data.wr    : inst.wr;
  assign s.size  = gnt ? data.size  : inst.size;
  assign s.wstrb = gnt ? data.wstrb : inst.wstrb;
  assign s.addr  = gnt ? data.addr  : inst.addr;
  assign s.wdata = gnt ? data.wdata : inst.wdata;

  assign inst.addr_ok = hs & ~gnt;
  assign data.addr_ok = hs &  gnt;
  assign inst.data_ok = pop & ~head;
  assign data.data_ok = pop &  head;
  assign inst.rdata   = s.rdata;
  assign data.rdata   = s.rdata;

  assign outstanding = cnt_q;
  assign err_orphan  = err_q;

  // Lock holds the grant across a stalled address phase; a locked
  // master dropping req is tolerated by releasing the lock.
  always_comb begin
    lock_d = lock_q;
    lown_d = lown_q;
    if (hs) begin
      lock_d = 1'b0;
    end else if (s_req) begin
      lock_d = 1'b1;
      lown_d = gnt;
    end else if (lock_q && !greq) begin
      lock_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_q <= 1'b0;
      lown_q <= 1'b0;
      fifo_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q   <= 1'b0;
`endif
    end else begin
      lock_q <= lock_d;
      lown_q <= lown_d;
      if (hs) begin
        fifo_q[wptr_q] <= gnt;
        wptr_q         <= inc(wptr_q);
      end
      if (pop)
        rptr_q <= inc(rptr_q);
      if (hs && !pop)
        cnt_q <= cnt_q + 1'b1;
      else if (pop && !hs)
        cnt_q <= cnt_q - 1'b1;
      if (s.data_ok && empty)
        err_q <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
      if (hs)
        rr_q <= ~gnt;
`endif
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Scoreboard bench for sram_like_arbiter: directed vectors push
// expected handshakes/returns; a negedge monitor pops and compares.
module tb_sram_like_arbiter;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  sram_like_arbiter_if inst_if ();
  sram_like_arbiter_if data_if ();
  sram_like_arbiter_if s_if ();

  logic [1:0] outstanding;
  logic       err_orphan;

  sram_like_arbiter #(
    .MAX_OUTSTANDING(2),
    .ADDR_W(32)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .inst(inst_if),
    .data(data_if),
    .s(s_if),
    .outstanding(outstanding),
    .err_orphan(err_orphan)
  );

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        own;
    logic [31:0] val;
  } exp_t;

  exp_t aq[$];
  exp_t dq[$];

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic ea(logic own, logic [31:0] a);
    aq.push_back({own, a});
  endtask

  task automatic ed(logic own, logic [31:0] d);
    dq.push_back({own, d});
  endtask

  task automatic drv(logic ir, logic [31:0] ia,
                     logic dr, logic [31:0] da,
                     logic aok, logic dok,
                     logic [31:0] rd);
    inst_if.req   = ir;
    inst_if.addr  = ia;
    data_if.req   = dr;
    data_if.addr  = da;
    s_if.addr_ok  = aok;
    s_if.data_ok  = dok;
    s_if.rdata    = rd;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // monitor
  always @(negedge clk) begin
    if (resetn) begin
      exp_t e;
      if (s_if.req && s_if.addr_ok) begin
        if (aq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL addr_unexp: got %h want none",
                   s_if.addr);
        end else begin
          e = aq.pop_front();
          chk("addr_own",
              {30'b0, data_if.addr_ok, inst_if.addr_ok},
              e.own ? 32'd2 : 32'd1);
          chk("s_addr", s_if.addr, e.val);
          chk("s_wr", {31'b0, s_if.wr}, {31'b0, e.own});
        end
      end else if (inst_if.addr_ok || data_if.addr_ok) begin
        chk("addr_ok_nohs",
            {30'b0, data_if.addr_ok, inst_if.addr_ok}, 0);
      end
      if (inst_if.data_ok || data_if.data_ok) begin
        if (dq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL data_unexp: got %h want none",
                   s_if.rdata);
        end else begin
          e = dq.pop_front();
          chk("dok_own",
              {30'b0, data_if.data_ok, inst_if.data_ok},
              e.own ? 32'd2 : 32'd1);
          chk("rdata",
              e.own ? data_if.rdata : inst_if.rdata, e.val);
        end
      end
    end
  end

  initial begin
    inst_if.wr    = 1'b0;
    inst_if.size  = 2'd2;
    inst_if.wstrb = 4'h0;
    inst_if.wdata = 32'h0;
    data_if.wr    = 1'b1;
    data_if.size  = 2'd2;
    data_if.wstrb = 4'hf;
    data_if.wdata = 32'hdeadbeef;

    // reset: everything quiet regardless of inputs
    drv(1, 32'h1c000000, 1, 32'h1000, 1, 1, 32'h12345678);
    #3;
    chk("rst_sreq", {31'b0, s_if.req}, 0);
    chk("rst_aok",
        {30'b0, inst_if.addr_ok, data_if.addr_ok}, 0);
    chk("rst_dok",
        {30'b0, inst_if.data_ok, data_if.data_ok}, 0);
    chk("rst_out", outstanding, 0);
    repeat (2) cyc();
    chk("rst_err", {31'b0, err_orphan}, 0);
    idle();
    resetn = 1'b1;
    cyc();

    // single inst fetch
    drv(1, 32'h1c000000, 0, 0, 1, 0, 0);
    ea(0, 32'h1c000000);
    @(negedge clk);
    chk("t1_iaok", {31'b0, inst_if.addr_ok}, 1);
    cyc();
    chk("t1_out1", outstanding, 1);
    drv(0, 0, 0, 0, 0, 1, 32'h02800c0c);
    ed(0, 32'h02800c0c);
    @(negedge clk);
    chk("t1_idok", {31'b0, inst_if.data_ok}, 1);
    cyc();
    chk("t1_out0", outstanding, 0);

    // both request: data first, in-order returns
    drv(1, 32'h1c000004, 1, 32'h1000, 1, 0, 0);
    ea(1, 32'h1000);
    cyc();
    drv(1, 32'h1c000004, 0, 32'h1000, 1, 0, 0);
    ea(0, 32'h1c000004);
    cyc();
    chk("t2_out2", outstanding, 2);
    drv(0, 0, 0, 0, 0, 1, 32'ha1);
    ed(1, 32'ha1);
    cyc();
    drv(0, 0, 0, 0, 0, 1, 32'hb2);
    ed(0, 32'hb2);
    cyc();
    idle();
    chk("t2_out0", outstanding, 0);

    // data stalled, inst rises: address held until hs
    drv(0, 0, 1, 32'h1000, 0, 0, 0);
    @(negedge clk);
    chk("t3_sreq", {31'b0, s_if.req}, 1);
    chk("t3_a0", s_if.addr, 32'h1000);
    cyc();
    drv(1, 32'h1c000008, 1, 32'h1000, 0, 0, 0);
    @(negedge clk);
    chk("t3_a1", s_if.addr, 32'h1000);
    cyc();
    @(negedge clk);
    chk("t3_a2", s_if.addr, 32'h1000);
    cyc();
    drv(1, 32'h1c000008, 1, 32'h1000, 1, 0, 0);
    ea(1, 32'h1000);
    cyc();
    drv(1, 32'h1c000008, 0, 32'h1000, 1, 0, 0);
    ea(0, 32'h1c000008);
    cyc();
    idle();
    chk("t3_out2", outstanding, 2);
    drv(0, 0, 0, 0, 0, 1, 32'h33);
    ed(1, 32'h33);
    cyc();
    drv(0, 0, 0, 0, 0, 1, 32'h44);
    ed(0, 32'h44);
    cyc();
    idle();

    // lock on inst beats later data request
    drv(1, 32'h1c00000c, 0, 0, 0, 0, 0);
    cyc();
    drv(1, 32'h1c00000c, 1, 32'h2000, 0, 0, 0);
    @(negedge clk);
    chk("t3l_addr", s_if.addr, 32'h1c00000c);
    cyc();
    drv(1, 32'h1c00000c, 1, 32'h2000, 1, 0, 0);
    ea(0, 32'h1c00000c);
    cyc();
    drv(0, 0, 1, 32'h2000, 1, 0, 0);
    ea(1, 32'h2000);
    cyc();
    drv(0, 0, 0, 0, 0, 1, 32'h55);
    ed(0, 32'h55);
    cyc();
    drv(0, 0, 0, 0, 0, 1, 32'h66);
    ed(1, 32'h66);
    cyc();
    idle();
    chk("t3l_out0", outstanding, 0);

    // full blocking, deferred push, push+pop same cycle
    drv(1, 32'h1c000010, 0, 0, 1, 0, 0);
    ea(0, 32'h1c000010);
    cyc();
    drv(1, 32'h1c000014, 0, 0, 1, 0, 0);
    ea(0, 32'h1c000014);
    cyc();
    drv(1, 32'h1c000018, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("t4_full_out", outstanding, 2);
    chk("t4_full_sreq", {31'b0, s_if.req}, 0);
    chk("t4_full_aok", {31'b0, inst_if.addr_ok}, 0);
    cyc();
    drv(1, 32'h1c000018, 0, 0, 1, 1, 32'hc3);
    ed(0, 32'hc3);
    @(negedge clk);
    chk("t4_popblk_sreq", {31'b0, s_if.req}, 0);
    cyc();
    chk("t4_out1", outstanding, 1);
    drv(1, 32'h1c000018, 0, 0, 1, 0, 0);
    ea(0, 32'h1c000018);
    cyc();
    chk("t4_out2", outstanding, 2);
    drv(0, 0, 0, 0, 0, 1, 32'hd4);
    ed(0, 32'hd4);
    cyc();
    drv(1, 32'h1c00001c, 0, 0, 1, 1, 32'he5);
    ea(0, 32'h1c00001c);
    ed(0, 32'he5);
    cyc();
    chk("t4_pushpop", outstanding, 1);
    drv(0, 0, 0, 0, 0, 1, 32'hf6);
    ed(0, 32'hf6);
    cyc();
    idle();
    chk("t4_out0", outstanding, 0);

    // orphan data_ok, then async reset mid-transaction
    drv(0, 0, 0, 0, 0, 1, 32'h77);
    @(negedge clk);
    chk("t5_orph_dok",
        {30'b0, inst_if.data_ok, data_if.data_ok}, 0);
    cyc();
    chk("t5_err1", {31'b0, err_orphan}, 1);
    drv(1, 32'h1c000020, 0, 0, 1, 0, 0);
    ea(0, 32'h1c000020);
    cyc();
    idle();
    chk("t5_out1", outstanding, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("t5_arst_out", outstanding, 0);
    chk("t5_arst_err", {31'b0, err_orphan}, 0);
    drv(1, 32'h1c000024, 0, 0, 1, 0, 0);
    #1;
    chk("t5_arst_sreq", {31'b0, s_if.req}, 0);
    idle();
    cyc();
    resetn = 1'b1;
    cyc();

`ifdef ARB_ROUND_ROBIN_EN
    // both requesting: inst, data, inst, data
    for (int r = 0; r < 2; r++) begin
      drv(1, 32'h1c000030, 1, 32'h3000, 1, 0, 0);
      ea(0, 32'h1c000030);
      cyc();
      ea(1, 32'h3000);
      cyc();
      drv(0, 0, 0, 0, 0, 1, 32'h88);
      ed(0, 32'h88);
      cyc();
      drv(0, 0, 0, 0, 0, 1, 32'h99);
      ed(1, 32'h99);
      cyc();
      idle();
    end
`endif

    repeat (3) cyc();
    chk("aq_empty", aq.size(), 0);
    chk("dq_empty", dq.size(), 0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Shares one sram-like slave port between the CPU's instruction master (inst_*) and data master (data_*).
- Arbitrates the address phase and locks the grant until the address handshake completes.
- Records each accepted request's owner in an in-order ID FIFO, and routes each data_ok/rdata back to the owner at the FIFO head.
- Sits between mycpu_top and the memory-side bridge/RAM, so the core can run on a single-port memory.

Parameters:
- MAX_OUTSTANDING, 2, depth of the owner-ID FIFO; maximum accepted requests without a returned data_ok (power of 2, ≥1).
- ADDR_W, 32, address/data width.

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- inst_req / inst_wr  in  1 / 1  instruction master request, write flag
- inst_size / inst_wstrb  in  2 / 4  transfer size, byte strobes
- inst_addr / inst_wdata  in  32 / 32  address, write data
- inst_addr_ok / inst_data_ok  out  1 / 1  address accepted; data returned
- inst_rdata  out  32  read data
- data_req … data_rdata  same set as inst_*  data master
- s_req, s_wr, s_size, s_wstrb, s_addr, s_wdata  out  1, 1, 2, 4, 32, 32  slave request
- s_addr_ok / s_data_ok  in  1 / 1  slave handshakes
- s_rdata  in  32  slave read data
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  current FIFO occupancy
- err_orphan  out  1  sticky flag: s_data_ok seen while FIFO empty

Behaviour:
- Reset (resetn=0, asynchronous): FIFO empty, pointers 0, outstanding=0, lock cleared, err_orphan=0, RR pointer = inst.
- During reset, s_req=0 and all *_addr_ok/*_data_ok=0 regardless of inputs.
- full = (outstanding==MAX_OUTSTANDING).
- Grant selection (combinational), in this order:
  - locked → lock owner;
  - else if data_req → data;
  - else if inst_req → inst;
  - else none.
- s_req = granted master's req & ~full. s_wr/s_size/s_wstrb/s_addr/s_wdata are a mux of the granted master; inst is selected when nothing is granted.
- Handshake hs = s_req & s_addr_ok. The granted master's addr_ok = hs; the other master's addr_ok = 0. No added latency on the address path.
- Lock register:
  - Set to the grant when s_req=1 & s_addr_ok=0.
  - Cleared on hs.
  - Cleared if the locked master deasserts req (protocol violation, tolerated).
  - While full, the lock is still held if already set.
- FIFO: on hs, push owner ID (0=inst, 1=data). On s_data_ok with FIFO non-empty, pop the head.
- Push and pop in the same cycle: occupancy unchanged, both pointers advance. Pointers wrap modulo MAX_OUTSTANDING.
- Return path (combinational): head owner's data_ok = s_data_ok & ~empty. Both inst_rdata and data_rdata = s_rdata.
- s_data_ok while FIFO empty: no master sees data_ok; err_orphan set and held until reset.
- full blocks new grants even when a pop occurs in the same cycle; the push is deferred to the next cycle.
- Writes also consume a FIFO entry and return through data_ok.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: when both masters request and no lock is held, grant the master not granted at the previous hs. RR pointer updates on each hs; reset value favours inst first.
- Undefined: fixed priority, data over inst; the RR pointer is not implemented.
- Lock, FIFO and return-path behaviour are identical either way.

Test Plan:
- Only inst_req=1, addr=0x1c000000, s_addr_ok=1 → s_addr=0x1c000000, inst_addr_ok=1 same cycle, outstanding=1. s_data_ok=1, s_rdata=0x02800c0c next cycle → inst_data_ok=1, inst_rdata=0x02800c0c, outstanding=0.
- inst_req and data_req both 1 (addr 0x1c000004 / 0x00001000), fixed priority → data granted first. Then inst. Two in-order data_ok pulses → data_data_ok first, then inst_data_ok.
- data_req=1 with s_addr_ok=0 for 3 cycles, inst_req rising in cycle 2 → s_addr stays 0x00001000 until handshake; inst granted only afterwards.
- MAX_OUTSTANDING=2, three back-to-back handshakes attempted with no data_ok → third s_req=0 while outstanding=2. A data_ok then frees a slot: same cycle still blocked, third handshake occurs the next cycle.
- s_data_ok=1 at idle → no master data_ok, err_orphan=1. Assert resetn=0 mid-transaction (outstanding=1) → outstanding=0, err_orphan=0 immediately, without waiting for a clock edge.
- With ARB_ROUND_ROBIN_EN, both masters requesting continuously, s_addr_ok=1 → grants alternate inst, data, inst, data.
